// File: rtl/gate_bank_self_test_pkg.sv
// Shared types, sizes and golden gate function for the six-gate bank self-test.
package gate_bank_self_test_pkg;

  localparam int unsigned NUM_VEC  = 8;
  localparam int unsigned VEC_W    = 3;
  localparam int unsigned Y_W      = 6;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned SETTLE_W = 4;

  localparam int unsigned Y_AND  = 0;
  localparam int unsigned Y_OR   = 1;
  localparam int unsigned Y_NAND = 2;
  localparam int unsigned Y_NOR  = 3;
  localparam int unsigned Y_XOR  = 4;
  localparam int unsigned Y_XNOR = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Expected bank outputs for one 3-bit input vector.
  function automatic logic [Y_W-1:0] golden_gates(input logic [VEC_W-1:0] vec);
    logic [Y_W-1:0] y;
    y          = '0;
    y[Y_AND]   = &vec;
    y[Y_OR]    = |vec;
    y[Y_NAND]  = ~&vec;
    y[Y_NOR]   = ~|vec;
    y[Y_XOR]   = ^vec;
    y[Y_XNOR]  = ~^vec;
    return y;
  endfunction

endpackage

// File: rtl/gate_bank_self_test_golden.sv
// Combinational 3->6 expected-output model of the gate bank.
module gate_golden_model
  import gate_bank_self_test_pkg::*;
(
  input  logic [VEC_W-1:0] vec_i,
  output logic [Y_W-1:0]   y_o
);

  assign y_o = golden_gates(vec_i);

endmodule

// File: rtl/gate_bank_self_test.sv
// Walks all 8 input vectors through the gate bank and checks the six outputs.
// Optional GATE_BANK_LOG_EN adds a per-vector capture log readable via log_addr/log_data.
module gate_bank_self_test
  import gate_bank_self_test_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [3:0]         a_out,
  input  logic [Y_W-1:0]     y_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [NUM_VEC-1:0] fail_mask,
  output logic [VEC_W-1:0]   first_fail_vec
`ifdef GATE_BANK_LOG_EN
  ,
  input  logic [VEC_W-1:0]   log_addr,
  output logic [Y_W-1:0]     log_data
`endif
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST =
    SETTLE_W'(SETTLE_CYCLES == 0 ? 0 : SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

  state_e               state_q, state_d;
  logic [VEC_W-1:0]     vec_q, vec_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic [3:0]           a_out_q, a_out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [CNT_W-1:0]     err_q, err_d;
  logic [NUM_VEC-1:0]   mask_q, mask_d;
  logic [VEC_W-1:0]     first_q, first_d;
  logic [Y_W-1:0]       expected;
  logic                 mismatch;

  gate_golden_model u_golden (
    .vec_i (a_out_q[3:1]),
    .y_o   (expected)
  );

  assign mismatch = (expected != y_in);

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      a_out_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      mask_q   <= '0;
      first_q  <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      a_out_q  <= a_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      mask_q   <= mask_d;
      first_q  <= first_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    a_out_d  = a_out_q;
    pass_d   = pass_q;
    err_d    = err_q;
    mask_d   = mask_q;
    first_d  = first_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_APPLY;
          vec_d   = '0;
          err_d   = '0;
          mask_d  = '0;
          first_d = '0;
          pass_d  = 1'b0;
        end
      end
      ST_APPLY: begin
        settle_d = '0;
        state_d  = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          err_d         = err_q + CNT_W'(1);
          mask_d[vec_q] = 1'b1;
          if (err_q == '0) begin
            first_d = vec_q;
          end
        end
        if (vec_q == LAST_VEC) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + VEC_W'(1);
          state_d = ST_APPLY;
        end
      end
      ST_DONE: begin
        vec_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    if (state_d == ST_APPLY) begin
      a_out_d = {vec_d, 1'b0};
    end
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      pass_d = (err_d == '0);
    end
    busy_d = (state_d == ST_APPLY) || (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
  end

  assign a_out          = a_out_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign fail_mask      = mask_q;
  assign first_fail_vec = first_q;

`ifdef GATE_BANK_LOG_EN
  logic [Y_W-1:0] log_q [NUM_VEC];

  // Capture log survives new runs; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_VEC; i++) begin
        log_q[i] <= '0;
      end
    end else if (state_q == ST_CHECK) begin
      log_q[a_out_q[3:1]] <= y_in;
    end
  end

  assign log_data = log_q[log_addr];
`endif

endmodule
